// File: rtl/dsmod1.sv
// First-order delta-sigma modulator: one output bit per clock, 1-clock latency, no backpressure.
// Asynchronous clr empties the integrator and forces out low.
module dsmod1 #(
    parameter int n = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic signed [n-1:0] in,
    output logic                out
);

    localparam int W = n + 2;
    localparam logic signed [W-1:0] HALF = {2'b00, 1'b1, {(n-1){1'b0}}};

    logic signed [W-1:0] integ;
    logic signed [W-1:0] fb;
    logic signed [W-1:0] integ_nxt;

    // Feedback is +/- half scale so the integrator stays within +/-2^n.
    always_comb begin
        fb        = out ? HALF : -HALF;
        integ_nxt = integ + {{2{in[n-1]}}, in} - fb;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            integ <= '0;
            out   <= 1'b0;
        end else begin
            integ <= integ_nxt;
            out   <= ~integ_nxt[W-1];
        end
    end

endmodule

// File: rtl/dsmod_ctl.sv
// Sample-rate controller for dsmod1: one-entry pending buffer, soft-mute ramp, underrun flag.
// Samples take effect at the next period boundary; in_ready drops while a sample is pending.
module dsmod_ctl #(
    parameter int n    = 16,
    parameter int osr  = 64,
    parameter int step = 256
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                mute,
    input  logic signed [n-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out,
    output logic                tick,
    output logic                underrun
);

    localparam int CW = $clog2(osr);
    localparam int NW = n + 1;
    localparam logic [CW-1:0]        CMAX   = CW'(osr - 1);
    localparam logic signed [NW-1:0] STEP_W = NW'(step);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MUTE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  en_q;
    logic                  mod_off;
    logic                  mod_clr;
    logic [CW-1:0]         cnt;
    logic signed [n-1:0]   cur;
    logic signed [n-1:0]   pend;
    logic                  pend_v;
    logic                  accept;
    logic signed [NW-1:0]  cur_x;
    logic signed [NW-1:0]  ramp_w;
    logic signed [n-1:0]   cur_ramp;

    assign tick     = en_q && (cnt == CMAX);
    assign in_ready = (state == MUTE) ? 1'b1 : ~pend_v;
    assign accept   = in_valid & in_ready;

    // Ramp one step toward zero in n+1 bits so -2^(n-1) cannot wrap.
    always_comb begin
        cur_x  = {cur[n-1], cur};
        ramp_w = '0;
        if (cur_x > 0) begin
            ramp_w = cur_x - STEP_W;
            if (ramp_w < 0) ramp_w = '0;
        end else if (cur_x < 0) begin
            ramp_w = cur_x + STEP_W;
            if (ramp_w > 0) ramp_w = '0;
        end
        cur_ramp = ramp_w[n-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (!en_q) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = mute ? MUTE : RUN;
                RUN:     if (tick && mute)  state_nxt = MUTE;
                MUTE:    if (tick && !mute) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            mod_off <= 1'b1;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            en_q    <= en;
            mod_off <= ~en_q;
            if (!en_q || cnt == CMAX) cnt <= '0;
            else                      cnt <= cnt + 1'b1;
        end
    end

    // Boundary behaviour follows the mute level sampled at that edge, so a
    // MUTE->RUN boundary already consumes (or underruns) like RUN.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            underrun <= 1'b0;
        end else if (!en_q) begin
            cur      <= '0;
            pend_v   <= 1'b0;
            underrun <= 1'b0;
        end else if (state == IDLE) begin
            cur      <= '0;
            underrun <= 1'b0;
            if (accept) begin
                pend   <= in;
                pend_v <= 1'b1;
            end
        end else if (tick) begin
            if (mute) begin
                cur    <= cur_ramp;
                pend_v <= 1'b0;
            end else if (pend_v) begin
                cur    <= pend;
                pend_v <= 1'b0;
            end else begin
                underrun <= 1'b1;
                if (accept) begin
                    pend   <= in;
                    pend_v <= 1'b1;
                end
            end
        end else if (state == MUTE) begin
            pend_v <= 1'b0;
        end else if (accept) begin
            pend   <= in;
            pend_v <= 1'b1;
        end
    end

    assign mod_clr = clr | mod_off;

    dsmod1 #(.n(n)) u_mod (
        .clk (clk),
        .clr (mod_clr),
        .in  (cur),
        .out (out)
    );

endmodule

// File: tb/tb_dsmod_ctl.sv
// Directed bench for dsmod_ctl (n=16, osr=4, step=0x1000) with a sample scoreboard.
module tb_dsmod_ctl;

    localparam int N    = 16;
    localparam int OSR  = 4;
    localparam int STEP = 32'h1000;

    logic                clk = 1'b0;
    logic                clr = 1'b1;
    logic                en = 1'b0;
    logic                mute = 1'b0;
    logic signed [N-1:0] in = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                out;
    logic                tick;
    logic                underrun;

    dsmod_ctl #(.n(N), .osr(OSR), .step(STEP)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mute     (mute),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .tick     (tick),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] sbq[$];
    logic [15:0] exp_cur = '0;
    logic        exp_und = 1'b0;
    logic        m_mute = 1'b0;
    logic        last_tk = 1'b0;
    bit          cnt_on = 0;
    bit          stream_rand = 0;
    int          stream_left = 0;
    int          ones = 0;
    int          accepts = 0;
    int          accepts0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] ramp(input logic [15:0] c);
        int v;
        v = int'(signed'(c));
        if (v > 0)      v = (v > STEP) ? v - STEP : 0;
        else if (v < 0) v = (v < -STEP) ? v + STEP : 0;
        return 16'(v);
    endfunction

    function automatic void model_reset();
        sbq.delete();
        exp_cur = '0;
        exp_und = 1'b0;
        m_mute  = 1'b0;
    endfunction

    // One clock: capture pre-edge handshake, advance, then score boundaries and acceptances.
    task automatic cyc();
        logic        tk, mt, ac;
        logic [15:0] iv;
        tk = tick;
        mt = mute;
        ac = in_valid & in_ready;
        iv = in;
        @(posedge clk);
        #1;
        if (cnt_on) ones += int'(out);
        last_tk = tk;
        if (tk) begin
            if (mt) begin
                exp_cur = ramp(exp_cur);
                sbq.delete();
            end else if (sbq.size() > 0) begin
                exp_cur = sbq.pop_front();
            end else begin
                exp_und = 1'b1;
            end
            m_mute = mt;
            chk("cur_at_tick", {16'h0, dut.cur}, {16'h0, exp_cur});
            chk("underrun_at_tick", underrun, exp_und);
        end
        if (ac) begin
            if (tk ? !mt : !m_mute) sbq.push_back(iv);
            accepts++;
            stream_left--;
            if (stream_left <= 0) in_valid = 1'b0;
            else if (stream_rand) in = 16'($urandom);
        end
    endtask

    task automatic wait_tick(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            seen = last_tk;
        end
        chk({tag, "_tick_seen"}, seen, 1);
    endtask

    task automatic feed(input logic [15:0] v, input int cnt, input bit rnd);
        in          = v;
        in_valid    = 1'b1;
        stream_left = cnt;
        stream_rand = rnd;
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_cur", {16'h0, dut.cur}, 0);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Constant half-scale stream: first sample ready immediately, ~75% ones.
        en = 1'b1;
        cyc();
        feed(16'h4000, 100000, 0);
        chk("ready_at_once", in_ready, 1);
        cyc();
        chk("ready_after_accept", in_ready, 0);
        wait_tick("first");
        chk("cur_first_tick", {16'h0, dut.cur}, 32'h4000);
        ones   = 0;
        cnt_on = 1;
        repeat (64 * OSR) cyc();
        cnt_on = 0;
        chk("ones_density_75pct", (ones >= 188 && ones <= 196), 1);
        chk("no_underrun_streaming", underrun, 0);

        // 100 random samples, in_valid held high throughout.
        accepts0 = accepts;
        feed(16'($urandom), 100, 1);
        for (int i = 0; i < 2000 && (in_valid || sbq.size() > 0); i++) cyc();
        chk("stream_drained", sbq.size(), 0);
        chk("stream_accepted_100", accepts - accepts0, 100);
        chk("no_underrun_after_stream", underrun, 0);

        // Starvation: next boundary underruns and holds cur; flag is sticky.
        wait_tick("starve");
        chk("underrun_set", underrun, 1);
        feed(16'h1234, 1, 0);
        wait_tick("refill");
        chk("cur_refill", {16'h0, dut.cur}, 32'h1234);
        chk("underrun_sticky", underrun, 1);
        en = 1'b0;
        repeat (3) cyc();
        model_reset();
        chk("dis_underrun", underrun, 0);
        chk("dis_out", out, 0);
        chk("dis_cur", {16'h0, dut.cur}, 0);
        chk("dis_in_ready", in_ready, 1);

        // Soft mute ramp from a positive value, then from full-scale negative.
        en = 1'b1;
        cyc();
        feed(16'h2800, 1, 0);
        wait_tick("m0");
        chk("mute_start", {16'h0, dut.cur}, 32'h2800);
        mute = 1'b1;
        wait_tick("m1");
        chk("mute_1800", {16'h0, dut.cur}, 32'h1800);
        wait_tick("m2");
        chk("mute_0800", {16'h0, dut.cur}, 32'h0800);
        wait_tick("m3");
        chk("mute_0000", {16'h0, dut.cur}, 32'h0000);
        wait_tick("m4");
        chk("mute_stays_0", {16'h0, dut.cur}, 32'h0000);
        mute = 1'b0;
        wait_tick("unmute");
        feed(16'h8000, 1, 0);
        wait_tick("neg");
        chk("neg_full_scale", {16'h0, dut.cur}, 32'h8000);
        mute = 1'b1;
        wait_tick("neg_ramp");
        chk("neg_ramp_m7000", {16'h0, dut.cur}, 32'h9000);

        // Asynchronous clear mid-period with a sample pending.
        mute = 1'b0;
        wait_tick("pre_clr");
        feed(16'h0100, 1, 0);
        cyc();
        chk("pend_before_clr", dut.pend_v, 1);
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out", out, 0);
        chk("clr_tick", tick, 0);
        chk("clr_underrun", underrun, 0);
        chk("clr_cur", {16'h0, dut.cur}, 0);
        chk("clr_pend_v", dut.pend_v, 0);
        #2;
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tick_after_reenable_%0d", i), tick, (i == 4) ? 1 : 0);
        end
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
